bram_axis_reader: RTL

BRAM_AXIS_READER -- requirements
Module: bram_axis_reader

---
 rtl/fir_pkg.sv | 15 +
 rtl/axis_skid_fifo.sv | 50 +++++
 rtl/bram_axis_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the BRAM-to-AXI-Stream reader: FSM state encoding
// and default datapath/address widths.
package fir_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO holding stream words plus sideband bits.
// Storage is not reset; only the pointers and occupancy are.
module axis_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/bram_axis_reader.sv
// Streams N words from a 1-cycle-latency BRAM onto an AXI-Stream master port.
// Define BRAM_AXIS_READER_TKEEP_EN to add the out_m_tkeep port.
module bram_axis_reader
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  in_ap_start,
  input  logic [ADDR_WIDTH:0]   in_data_num,
  output logic                  out_ap_done,
  output logic                  out_ap_idle,
  output logic [ADDR_WIDTH-1:0] out_A,
  output logic                  out_EN,
  input  logic [DATA_WIDTH-1:0] in_Do,
  output logic                  out_m_tvalid,
  output logic [DATA_WIDTH-1:0] out_m_tdata,
  output logic                  out_m_tlast,
  input  logic                  in_m_tready
`ifdef BRAM_AXIS_READER_TKEEP_EN
  ,
  output logic [DATA_WIDTH/8-1:0] out_m_tkeep
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] num_q, num_d;
  logic [ADDR_WIDTH:0] rd_cnt_q, rd_cnt_d;
  logic                infl_q, infl_last_q;
  logic                rd_en, rd_ok, is_last_rd, pop;
  logic                fifo_full, fifo_empty;
  logic [DATA_WIDTH:0] fifo_head;
  logic [2:0]          level;

  assign pop        = out_m_tvalid & in_m_tready;
  assign is_last_rd = (rd_cnt_q == (num_q - (ADDR_WIDTH+1)'(1)));

  // Queued words plus the read still in the BRAM pipe must leave room after this cycle's pop.
  assign level = (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1)) + {2'b00, infl_q};
  assign rd_ok = (level < 3'd2) || ((level == 3'd2) && pop);

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    rd_cnt_d = rd_cnt_q;
    rd_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_ap_start) begin
          num_d    = in_data_num;
          rd_cnt_d = '0;
          state_d  = (in_data_num == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_ok) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + (ADDR_WIDTH+1)'(1);
          if (is_last_rd) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_head[DATA_WIDTH]) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      rd_cnt_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      rd_cnt_q    <= rd_cnt_d;
      infl_q      <= rd_en;
      infl_last_q <= rd_en & is_last_rd;
    end
  end

  // BRAM data is valid the cycle after out_EN and is captured with its tlast tag.
  axis_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .push_i (infl_q),
    .din_i  ({infl_last_q, in_Do}),
    .pop_i  (pop),
    .dout_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign out_EN       = rd_en;
  assign out_A        = rd_en ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign out_ap_done  = (state_q == ST_DONE);
  assign out_ap_idle  = (state_q == ST_IDLE);
  assign out_m_tvalid = ~fifo_empty;
  assign out_m_tdata  = fifo_head[DATA_WIDTH-1:0];
  assign out_m_tlast  = out_m_tvalid & fifo_head[DATA_WIDTH];

`ifdef BRAM_AXIS_READER_TKEEP_EN
  assign out_m_tkeep = out_m_tvalid ? '1 : '0;
`endif

endmodule
